// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch stage. It holds the PC and drives a word address to a
// combinational instruction memory. Each fetched instruction is buffered
// together with its PC+4 in a DEPTH-entry FIFO that feeds decode.
// A branch redirect flushes the FIFO and reloads the PC.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   ADDR_W    instruction memory word-address width
//   RESET_PC  PC value after reset
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_addr       word address to instruction memory (pc[ADDR_W+1:2])
//   imem_rdata      instruction at imem_addr, returned in the same cycle
//   out_valid       FIFO head is valid
//   out_ready       decode accepts the FIFO head
//   out_instr       head instruction, 0 when empty
//   out_pc_next     head PC+4, 0 when empty
//   redirect_valid  flush request / taken branch
//   redirect_pc     new PC; bits [1:0] are forced to 0
//   count           current FIFO occupancy
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetch      number of pushes since reset (wraps at 2^32)
//   perf_flush      number of entries discarded by redirects (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc_next,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetch,
    output logic [31:0]                perf_flush
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pcn_q   [DEPTH];
    logic          push;
    logic          pop;

    // The two low bits of a redirect target are ignored.
    logic [1:0]    unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[ADDR_W+1:2];

    // Output handshake: the head entry transfers on any cycle where
    // out_valid && out_ready. out_valid depends only on the registered
    // occupancy, never on out_ready. Once raised, it stays high until the
    // entry is taken, or until a redirect or reset clears the queue.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // A full queue can still accept a push when the head leaves in the same
    // cycle. A redirect suppresses fetch for that cycle. The instruction at
    // the old PC is stale.
    assign push = !redirect_valid && ((count < CW'(DEPTH)) || pop);

    assign out_instr   = out_valid ? instr_q[rd_ptr] : 32'd0;
    assign out_pc_next = out_valid ? pcn_q[rd_ptr]   : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            // Any pop this cycle still counts as delivered. Everything left
            // in the queue is dropped.
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc_plus4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage has no reset. Empty entries are masked at the outputs.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_q[wr_ptr] <= imem_rdata;
            pcn_q[wr_ptr]   <= pc_plus4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (push) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush <= perf_flush + 32'(count) - 32'(pop);
            end
        end
    end
`endif

endmodule
